plc_tx_frame_ctrl: RTL

Transmit-side sequencer for the PLC datapath. It pulls payload bytes from the TX FIFO, prefixes each frame with a preamble and an SFD, and hands bytes to the serializer over a valid/ready handshake. It also issues the frame-start pulse that re-seeds the scrambler, and enforces an inter-frame gap. It sits between the FIFO and the serializer and replaces ad-hoc sequencing in the testbench.

---
 rtl/plc_tx_frame_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/plc_tx_frame_ctrl.sv
// plc_tx_frame_ctrl: transmit frame sequencer between the TX FIFO
// and the serializer (preamble, SFD, payload, inter-frame gap).
module plc_tx_frame_ctrl #(
    parameter int unsigned       DATA_W        = 8,
    parameter int unsigned       LEN_W         = 8,
    parameter int unsigned       PREAMBLE_LEN  = 2,
    parameter logic [DATA_W-1:0] PREAMBLE_BYTE = 8'h55,
    parameter logic [DATA_W-1:0] SFD_BYTE      = 8'hD5,
    parameter int unsigned       GAP_CYCLES    = 16,
    parameter int unsigned       UNDERRUN_TO   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_req,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              piso_ready,
    output logic              piso_load,
    output logic [DATA_W-1:0] piso_data,
    output logic              piso_start,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int unsigned PRE_W   = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int unsigned STALL_W = $clog2(UNDERRUN_TO + 1);

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(PREAMBLE_LEN - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(UNDERRUN_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_PRE, S_SFD, S_RD, S_CAP, S_TX, S_GAP
    } state_t;

    state_t              r_state, w_state;
    logic [PRE_W-1:0]    r_pre,   w_pre;
    logic [GAP_W-1:0]    r_gap,   w_gap;
    logic [STALL_W-1:0]  r_stall, w_stall;
    logic [LEN_W-1:0]    r_rem,   w_rem;
    logic [DATA_W-1:0]   r_data,  w_data;
    logic                r_done,  w_done;
    logic                r_und,   w_und;
    logic                w_load;
    logic [DATA_W-1:0]   w_pdata;
    logic                w_start;
    logic                w_rd;

    // State and datapath registers; reset abandons any partial byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_gap   <= '0;
            r_stall <= '0;
            r_rem   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_und   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pre   <= w_pre;
            r_gap   <= w_gap;
            r_stall <= w_stall;
            r_rem   <= w_rem;
            r_data  <= w_data;
            r_done  <= w_done;
            r_und   <= w_und;
        end
    end

    // Next-state, counter updates and handshake outputs.
    always_comb begin
        w_state = r_state;
        w_pre   = r_pre;
        w_gap   = r_gap;
        w_stall = r_stall;
        w_rem   = r_rem;
        w_data  = r_data;
        w_done  = 1'b0;
        w_und   = 1'b0;
        w_load  = 1'b0;
        w_pdata = '0;
        w_start = 1'b0;
        w_rd    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (frame_req && frame_len != '0) begin
                    w_rem   = frame_len;
                    w_state = S_START;
                end
            end
            S_START: begin
                w_start = 1'b1;
                w_pre   = '0;
                w_stall = '0;
                w_state = S_PRE;
            end
            S_PRE: begin
                w_load  = 1'b1;
                w_pdata = PREAMBLE_BYTE;
                if (piso_ready) begin
                    if (r_pre == PRE_LAST) begin
                        w_pre   = '0;
                        w_state = S_SFD;
                    end else begin
                        w_pre = r_pre + PRE_W'(1);
                    end
                end
            end
            S_SFD: begin
                w_load  = 1'b1;
                w_pdata = SFD_BYTE;
                if (piso_ready) begin
                    w_stall = '0;
                    w_state = S_RD;
                end
            end
            S_RD: begin
                if (!fifo_empty) begin
                    w_rd    = 1'b1;
                    w_stall = '0;
                    w_state = S_CAP;
                end else if (r_stall == STALL_LAST) begin
                    w_und   = 1'b1;
                    w_stall = '0;
                    w_gap   = '0;
                    w_state = S_GAP;
                end else begin
                    w_stall = r_stall + STALL_W'(1);
                end
            end
            S_CAP: begin
                w_data  = fifo_rdata;
                w_state = S_TX;
            end
            S_TX: begin
                w_load  = 1'b1;
                w_pdata = r_data;
                if (piso_ready) begin
                    if (r_rem == LEN_W'(1)) begin
                        w_rem   = '0;
                        w_done  = 1'b1;
                        w_gap   = '0;
                        w_state = S_GAP;
                    end else begin
                        w_rem   = r_rem - LEN_W'(1);
                        w_state = S_RD;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_gap   = '0;
                    w_state = S_IDLE;
                end else begin
                    w_gap = r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign fifo_rd_en = w_rd;
    assign piso_load  = w_load;
    assign piso_data  = w_pdata;
    assign piso_start = w_start;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_done;
    assign underrun   = r_und;

endmodule
